// File: rtl/rom_fetch32_if.sv
// Handshake and ROM-port bundle for the 32-bit instruction fetcher.
// master: the fetcher side. slave: the ROM-plus-core side.
interface rom_fetch32_if #(
  parameter int AW = 10
);
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_dout;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;

  modport master (
    output mem_addr, out_valid, out_data, out_addr,
    input  mem_dout, redirect, redirect_addr, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_data, out_addr,
    output mem_dout, redirect, redirect_addr, out_ready
  );
endinterface

// File: rtl/rom_fetch32.sv
// Reader for a synchronous 16-bit ROM with 1-cycle registered read latency.
// Fetches two consecutive words (even address first) and presents them as
// one 32-bit instruction over valid/ready. A redirect pulse restarts the
// fetch at a new even address, discarding any half-assembled word.
module rom_fetch32 #(
  parameter int AW         = 10,
  parameter int START_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  rom_fetch32_if.master  bus
);

  localparam logic [AW-1:0] START_PC = AW'(START_ADDR) & ~AW'(1);

  // LO: address the low word. HI: address the high word, capture the low.
  // CAP: capture the high word and present. HOLD: wait for the consumer while
  // the next low word is already addressed.
  typedef enum logic [1:0] {
    S_LO,
    S_HI,
    S_CAP,
    S_HOLD
  } state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [15:0]   lo_q;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic [AW-1:0] out_addr_q;

  // ROM address is decoded from registers only: odd word while fetching the high half.
  assign bus.mem_addr  = {pc_q[AW-1:1], (state_q == S_HI) || (state_q == S_CAP)};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;

  // Fetch FSM with registered outputs; redirect overrides every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      state_q     <= S_LO;
      pc_q        <= START_PC;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else if (bus.redirect) begin
      // A handshake in this cycle still completes; the consumer squashes it.
      state_q     <= S_LO;
      pc_q        <= {bus.redirect_addr[AW-1:1], 1'b0};
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_LO: begin
          state_q <= S_HI;
        end
        S_HI: begin
          lo_q    <= bus.mem_dout;
          state_q <= S_CAP;
        end
        S_CAP: begin
          out_data_q  <= {bus.mem_dout, lo_q};
          out_addr_q  <= pc_q;
          out_valid_q <= 1'b1;
          pc_q        <= pc_q + AW'(2);
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          // mem_addr already points at the next low word, so skip LO.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_HI;
          end
        end
        default: begin
          state_q <= S_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch32.sv
// Directed bench for rom_fetch32 with a 1-cycle registered ROM model and a
// scoreboard of expected {addr, data} words refilled on reset and redirect.
module tb_rom_fetch32;

  localparam int AW = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } word_t;

  logic clk;
  logic rst;
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rom_q;

  word_t sb[$];
  int n_checks;
  int n_errors;
  int n_acc;

  rom_fetch32_if #(.AW(AW)) bus ();

  rom_fetch32 #(.AW(AW), .START_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM: registers word[mem_addr] on the shared clock edge.
  always @(posedge clk) rom_q <= mem[bus.mem_addr];
  assign bus.mem_dout = rom_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [AW-1:0] a);
    logic [AW-1:0] a1;
    a1 = a + AW'(1);
    return {mem[a1], mem[a]};
  endfunction

  task automatic fill(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    word_t w;
    a = start;
    for (int k = 0; k < n; k++) begin
      w.addr = a;
      w.data = exp_word(a);
      sb.push_back(w);
      a = a + AW'(2);
    end
  endtask

  // One clock: monitor handshakes at negedge, then return 1 time unit after posedge.
  task automatic step();
    word_t w;
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      n_acc++;
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        check("sb_addr", 64'(bus.out_addr), 64'(w.addr));
        check("sb_data", 64'(bus.out_data), 64'(w.data));
      end
    end
    if (bus.redirect) begin
      sb.delete();
      fill({bus.redirect_addr[AW-1:1], 1'b0}, 8);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int acc0;

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_acc    = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'((i * 40503 + 4951) & 16'hFFFF);
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    bus.out_ready     = 1'b1;
    rst = 1'b0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_addr", 64'(bus.out_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill(0, 8);

    // 1. first word appears on the 3rd edge after release
    step();
    check("t1_valid_e1", 64'(bus.out_valid), 64'd0);
    step();
    check("t1_valid_e2", 64'(bus.out_valid), 64'd0);
    step();
    check("t1_valid_e3", 64'(bus.out_valid), 64'd1);
    check("t1_data", 64'(bus.out_data), 64'hABCD1234);
    check("t1_addr", 64'(bus.out_addr), 64'd0);
    step();  // accepted; now HI

    // 2. restart at 0, then stall the consumer for 5 cycles
    bus.out_ready     = 1'b0;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'h000;
    step();
    bus.redirect = 1'b0;
    steps(3);
    for (int k = 0; k < 5; k++) begin
      check("t2_valid", 64'(bus.out_valid), 64'd1);
      check("t2_data", 64'(bus.out_data), 64'hABCD1234);
      check("t2_addr", 64'(bus.out_addr), 64'd0);
      check("t2_mem_addr", 64'(bus.mem_addr), 64'd2);
      step();
    end
    acc0 = n_acc;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    steps(5);
    check("t2_one_accept", 64'(n_acc - acc0), 64'd1);

    // 3. redirect while in HI: word 2 accepted, then redirect to 0x105
    bus.out_ready = 1'b1;
    step();  // accepts word at 2, enters HI
    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'h105;
    step();
    bus.redirect = 1'b0;
    steps(3);
    check("t3_valid", 64'(bus.out_valid), 64'd1);
    check("t3_addr", 64'(bus.out_addr), 64'h104);
    check("t3_data", 64'(bus.out_data), 64'(exp_word(10'h104)));

    // 4. redirect in the same cycle as a handshake
    acc0 = n_acc;
    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'h200;
    step();
    bus.redirect = 1'b0;
    check("t4_handshake", 64'(n_acc - acc0), 64'd1);
    steps(3);
    check("t4_valid", 64'(bus.out_valid), 64'd1);
    check("t4_addr", 64'(bus.out_addr), 64'h200);
    step();

    // 5. wrap at the top of the address space
    bus.redirect      = 1'b1;
    bus.redirect_addr = 10'h3FE;
    step();
    bus.redirect = 1'b0;
    acc0 = n_acc;
    steps(11);
    check("t5_three_words", 64'(n_acc - acc0), 64'd3);

    // 6. asynchronous reset while in CAP
    #2 rst = 1'b1;
    #1;
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("t6_data", 64'(bus.out_data), 64'd0);
    check("t6_addr", 64'(bus.out_addr), 64'd0);
    step();
    rst = 1'b0;
    sb.delete();
    fill(0, 8);
    acc0 = n_acc;
    steps(7);
    check("t6_restart_words", 64'(n_acc - acc0), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
